fft_sequencer: RTL

Memory-mapped sequencer for the 4-point FFT datapath. It fetches four packed complex input points from memory and loads them into the FFT core's input registers. It then captures the four core outputs, writes them back to fixed result addresses, and finishes by writing a done flag word. It sits between the system memory bus and the FFT core, and is the only block that drives the core's load enable.

---
 rtl/fft_sequencer_pkg.sv | 37 +++
 rtl/fft_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fft_sequencer_pkg.sv
// ============================================================================
// fft_sequencer_pkg
// Shared constants and state encoding for the 4-point FFT sequencer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_sequencer_pkg;

  // Default bus map
  localparam logic [31:0] IN_BASE   = 32'h0040_0000;
  localparam logic [31:0] OUT_BASE  = 32'h0040_0100;
  localparam logic [31:0] STRIDE    = 32'h0000_0010;
  localparam logic [31:0] DONE_ADDR = 32'h0040_0060;

  // Packed complex point: {real[31:16], imag[15:0]}
  localparam int POINT_W = 32;
  localparam int HALF_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_WRITE   = 3'd4,
    S_FLAG    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Address of point idx relative to a base
  function automatic logic [31:0] point_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + (STRIDE * {30'd0, idx});
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sequencer.sv
// ============================================================================
// fft_sequencer
// Fetches four complex points over the memory bus, loads them into the FFT
// core, captures the core results, writes them back and writes a done flag.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sequencer
  import fft_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] rd_data,
  input  logic [31:0] fft_out0,
  input  logic [31:0] fft_out1,
  input  logic [31:0] fft_out2,
  input  logic [31:0] fft_out3,
  output logic        re,
  output logic        we,
  output logic [31:0] address,
  output logic [31:0] data_out,
  output logic [31:0] fft_in0,
  output logic [31:0] fft_in1,
  output logic [31:0] fft_in2,
  output logic [31:0] fft_in3,
  output logic        fft_load,
  output logic        busy,
  output logic        done
);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_idx;
  logic [POINT_W-1:0]     r_in_buf  [4];
  logic [POINT_W-1:0]     r_out_buf [4];
  logic                   w_enter_burst;
  logic                   w_xfer;

  // A new burst (READ or WRITE) always starts from point 0
  assign w_enter_burst = (w_next != r_state) && ((w_next == S_READ) || (w_next == S_WRITE));
  assign w_xfer        = (re || we) && mem_ready;

  // Core sees the input buffer directly; it only latches it on fft_load
  assign fft_in0 = r_in_buf[0];
  assign fft_in1 = r_in_buf[1];
  assign fft_in2 = r_in_buf[2];
  assign fft_in3 = r_in_buf[3];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and bus/control outputs; bus fields are zero outside accesses
  always_comb begin
    w_next   = r_state;
    re       = 1'b0;
    we       = 1'b0;
    address  = 32'd0;
    data_out = 32'd0;
    fft_load = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_READ;
      end
      S_READ: begin
        re      = 1'b1;
        address = point_addr(IN_BASE, r_idx);
        if (mem_ready && (r_idx == 2'd3)) w_next = S_LOAD;
      end
      S_LOAD: begin
        fft_load = 1'b1;
        w_next   = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_next = S_WRITE;
      end
      S_WRITE: begin
        we       = 1'b1;
        address  = point_addr(OUT_BASE, r_idx);
        data_out = r_out_buf[r_idx];
        if (mem_ready && (r_idx == 2'd3)) w_next = S_FLAG;
      end
      S_FLAG: begin
        we       = 1'b1;
        address  = DONE_ADDR;
        data_out = 32'h0000_0001;
        if (mem_ready) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Point index: advances only on a completed access
  always_ff @(posedge clk) begin
    if (reset)              r_idx <= 2'd0;
    else if (w_enter_burst) r_idx <= 2'd0;
    else if (w_xfer)        r_idx <= r_idx + 2'd1;
  end

  // Input buffer: capture read data on each completed read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_in_buf[k] <= '0;
    end else if ((r_state == S_READ) && mem_ready) begin
      r_in_buf[r_idx] <= rd_data;
    end
  end

  // Output buffer: grab the settled core results at the end of COMPUTE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_out_buf[k] <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_out_buf[0] <= fft_out0;
      r_out_buf[1] <= fft_out1;
      r_out_buf[2] <= fft_out2;
      r_out_buf[3] <= fft_out3;
    end
  end

endmodule

`default_nettype wire
